// File: rtl/uart_tx_scheduler_if.sv
// Bundles the CPU write port, the baud timer handshake and the serial line for uart_tx_scheduler.
interface uart_tx_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             clr_ovf;
    logic             baud_tick;
    logic             baud_run;
    logic             tx;
    logic             tx_busy;
    logic             tx_done;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             ovf;

    modport master (
        output wr_en, wr_data, clr_ovf, baud_tick,
        input  baud_run, tx, tx_busy, tx_done, fifo_count, fifo_full, ovf
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, baud_tick,
        output baud_run, tx, tx_busy, tx_done, fifo_count, fifo_full, ovf
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART transmit sequencer: queues CPU bytes in a small FIFO and shifts them out as
// back-to-back frames, holding the baud timer enabled for the whole burst.
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    uart_tx_scheduler_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 baud_run_q, baud_run_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;

    logic fifo_full, fifo_empty, pop, push, tick, frame_end;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Ticks only count once the timer has been enabled for at least one cycle.
    assign tick       = bus.baud_tick && baud_run_q;
    assign frame_end  = tick && (stop_cnt_q == STOP_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: if (tick) state_d = DATA;
            DATA:  if (tick && bit_cnt_q == BIT_LAST) state_d = STOP;
            STOP: begin
                if (frame_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs and shifter ----------------
    always_comb begin
        tx_d       = tx_q;
        baud_run_d = baud_run_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                baud_run_d = 1'b0;
                tx_busy_d  = 1'b0;
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
                    tx_d       = 1'b0;
                    baud_run_d = 1'b1;
                    tx_busy_d  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (frame_end) begin
                    tx_done_d = 1'b1;
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                    end else begin
                        baud_run_d = 1'b0;
                        tx_busy_d  = 1'b0;
                    end
                end else if (tick) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    // ---------------- FIFO bookkeeping ----------------
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign push = bus.wr_en && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (bus.wr_en && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            baud_run_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            baud_run_q <= baud_run_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.baud_run   = baud_run_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.fifo_count = count_q;
    assign bus.fifo_full  = fifo_full;
    assign bus.ovf        = ovf_q;
endmodule
